// File: rtl/relogio_pkg.sv
// relogio_pkg: shared types, limits and BCD helpers for the clock stages
package relogio_pkg;
    typedef enum logic [1:0] {IDLE, ESPERA, REPETE} ajuste_t;
    localparam logic [1:0] HORA_MAX_MSD = 2'd2;
    localparam logic [3:0] HORA_MAX_LSD = 4'd3;
    localparam logic [3:0] BCD_MAX = 4'd9;
    typedef struct packed {logic [1:0] msd; logic [3:0] lsd;} hora_t;
    typedef struct packed {hora_t d; logic pm;} disp_t;
    // one BCD hour step; 23 and any illegal code fall back to 00
    function automatic hora_t bcd_inc_hora(hora_t h);
        logic bad;
        bad = h.lsd > BCD_MAX || h.msd > HORA_MAX_MSD || (h.msd == HORA_MAX_MSD && h.lsd >= HORA_MAX_LSD);
        return bad ? hora_t'(6'd0) : h.lsd == BCD_MAX ? hora_t'({h.msd + 2'd1, 4'd0}) : hora_t'({h.msd, h.lsd + 4'd1});
    endfunction
    // 24h BCD to 12h digits plus pm flag
    function automatic disp_t bcd24_para_12(hora_t h);
        if (h == hora_t'(6'd0)) return {2'd1, 4'd2, 1'b0};
        if (h.msd == 2'd0 || (h.msd == 2'd1 && h.lsd < 4'd2)) return {h, 1'b0};
        if (h.msd == 2'd1 && h.lsd == 4'd2) return {h, 1'b1};
        if (h.msd == 2'd1) return {2'd0, h.lsd - 4'd2, 1'b1};
        return h.lsd < 4'd2 ? {2'd0, h.lsd + 4'd8, 1'b1} : {2'd1, h.lsd - 4'd2, 1'b1};
    endfunction
endpackage

// File: rtl/maq_h_if.sv
// maq_h_if: hours stage control inputs and display outputs
//   master drives enable/incremento/ajuste/modo12, slave drives Lsd/Msd/pm/incrementadia
interface maq_h_if;
    logic       maqh_enable;
    logic       maqh_incremento;
    logic       maqh_ajuste;
    logic       maqh_modo12;
    logic [3:0] maqh_Lsd;
    logic [1:0] maqh_Msd;
    logic       maqh_pm;
    logic       maqh_incrementadia;
    modport master (output maqh_enable, maqh_incremento, maqh_ajuste, maqh_modo12,
                    input maqh_Lsd, maqh_Msd, maqh_pm, maqh_incrementadia);
    modport slave (input maqh_enable, maqh_incremento, maqh_ajuste, maqh_modo12,
                   output maqh_Lsd, maqh_Msd, maqh_pm, maqh_incrementadia);
endinterface

// File: rtl/maq_h_ajuste.sv
// maq_h_ajuste: button hold-to-auto-repeat FSM
//   clock/reset: sync active-high; ajuste: button level; adj_step: step pulse (same cycle as the deciding sample)
module maq_h_ajuste import relogio_pkg::*; #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int REPEAT_CYCLES = 12_500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic ajuste,
    output logic adj_step
);
    localparam int TW = $clog2(HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES);
    localparam logic [TW-1:0] HOLD_END = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_END = TW'(REPEAT_CYCLES - 1);
    ajuste_t state;
    logic [TW-1:0] timer;
    // step is decided from the current state and button so the count moves on the same edge
    always_comb adj_step = ajuste & (state == IDLE || (state == ESPERA && timer == HOLD_END) || (state == REPETE && timer == REP_END));
    always_ff @(posedge clock) begin
        if (reset || !ajuste) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            case (state)
                IDLE:    begin state <= ESPERA; timer <= '0; end
                ESPERA:  begin state <= timer == HOLD_END ? REPETE : ESPERA; timer <= timer == HOLD_END ? '0 : timer + 1'b1; end
                REPETE:  timer <= timer == REP_END ? '0 : timer + 1'b1;
                default: begin state <= IDLE; timer <= '0; end
            endcase
        end
    end
endmodule

// File: rtl/maq_h.sv
// maq_h: 24h BCD hours counter with carry/adjust stepping, 12/24h display and day pulse
//   maqh_clock/maqh_reset: clock and sync active-high reset; bus: maq_h_if.slave
module maq_h import relogio_pkg::*; #(
    parameter int RST_HORA = 0,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int REPEAT_CYCLES = 12_500_000
) (
    input logic maqh_clock,
    input logic maqh_reset,
    maq_h_if.slave bus
);
    localparam hora_t RST_BCD = {2'(RST_HORA / 10), 4'(RST_HORA % 10)};
    hora_t count, nxt, base;
    disp_t disp;
    logic adj_step, carry_step;
    maq_h_ajuste #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_ajuste (
        .clock(maqh_clock),
        .reset(maqh_reset),
        .ajuste(bus.maqh_ajuste),
        .adj_step(adj_step)
    );
    // display follows the value the count takes on this edge, including the reset value
    always_comb begin
        carry_step = bus.maqh_enable & bus.maqh_incremento;
        nxt = carry_step | adj_step ? bcd_inc_hora(count) : count;
        base = maqh_reset ? RST_BCD : nxt;
        disp = bus.maqh_modo12 ? bcd24_para_12(base) : {base, 1'b0};
    end
    always_ff @(posedge maqh_clock) begin
        count <= base;
        bus.maqh_incrementadia <= !maqh_reset && carry_step && count == hora_t'({HORA_MAX_MSD, HORA_MAX_LSD});
        bus.maqh_Msd <= disp.d.msd;
        bus.maqh_Lsd <= disp.d.lsd;
        bus.maqh_pm <= disp.pm;
    end
endmodule

// File: doc/maq_h.md
Name: maq_h

Overview:
- Hours stage of the digital clock. Sits directly downstream of the minutes machine and consumes its hour-increment pulse.
- Keeps the hour of day as a 24h BCD count (00..23). Produces registered display digits in 24h or 12h format, plus a one-cycle day-rollover pulse.
- Includes a button-driven adjust path with hold-to-auto-repeat, so the hour can be set whether or not the clock is running.

Parameters:
- RST_HORA, 0, hour loaded on reset (0..23, binary value, stored as BCD).
- HOLD_CYCLES, 50_000_000, cycles maqh_ajuste must stay high after the first step before auto-repeat starts (must be >=2).
- REPEAT_CYCLES, 12_500_000, cycles between auto-repeat steps (must be >=2).

Ports:
- maqh_clock  input  1  single clock, all state on its rising edge.
- maqh_reset  input  1  synchronous, active-high reset.
- maqh_enable  input  1  gates the carry increment path only.
- maqh_incremento  input  1  one-cycle carry pulse from the minutes stage (59→00).
- maqh_ajuste  input  1  adjust button level, already synchronized and debounced upstream.
- maqh_modo12  input  1  1 = 12h display, 0 = 24h display.
- maqh_Lsd  output  4  hour units digit, BCD, registered.
- maqh_Msd  output  2  hour tens digit, BCD, registered.
- maqh_pm  output  1  PM indicator, registered; forced 0 in 24h mode.
- maqh_incrementadia  output  1  one-cycle day-rollover pulse, registered.

Behaviour:
- Reset: maqh_reset is synchronous and active-high; there is one clock, maqh_clock. When reset is sampled high:
  - count = RST_HORA;
  - adjust FSM = IDLE, timer = 0;
  - maqh_incrementadia = 0;
  - maqh_Lsd, maqh_Msd and maqh_pm = the display mapping of RST_HORA under the current maqh_modo12.
  - Reset mid-adjust aborts the repeat; the next step requires a fresh press.
- Increment of the count (BCD, one step):
  - 23 → 00;
  - units 9 → units 0, tens +1;
  - otherwise units +1.
  - Any illegal BCD value (units >9, tens >2, or 2x with x >3) → 00.
- Carry path: carry_step = maqh_enable & maqh_incremento.
- Adjust path: adj_step is an internal pulse from the FSM. It is not gated by maqh_enable.
- Simultaneous carry_step and adj_step in the same cycle: the count advances by exactly one.
- maqh_incrementadia = 1 for one cycle, on the same edge the count wraps 23→00, only when carry_step is 1 in that cycle. A wrap caused by adjust alone gives no pulse.
- Adjust FSM (timer width = clog2 of max(HOLD_CYCLES, REPEAT_CYCLES)):
  - IDLE: if maqh_ajuste=1, then adj_step=1, go to ESPERA, timer=0.
  - ESPERA: if maqh_ajuste=0, go to IDLE. Else timer+1; when timer == HOLD_CYCLES-1, then adj_step=1, go to REPETE, timer=0.
  - REPETE: if maqh_ajuste=0, go to IDLE. Else timer+1; when timer == REPEAT_CYCLES-1, then adj_step=1, timer=0.
  - Release in any state returns to IDLE with no step.
  - A press spanning 1 cycle gives exactly one step.
- Display mapping (registered from the next count and the current maqh_modo12, so the display updates on the same edge as the count):
  - 24h mode: digits = count, pm = 0.
  - 12h mode:
    - 00 → 12, pm = 0;
    - 01..11 → same, pm = 0;
    - 12 → 12, pm = 1;
    - 13..23 → count−12, pm = 1.
  - A change of maqh_modo12 alone shows on the display at the next edge.
- Latency: from the step condition sampled at edge N, count, display and day pulse are all valid after edge N.

Decomposition:
- Shared package relogio_pkg holds:
  - typedef enum for the adjust FSM states {IDLE, ESPERA, REPETE};
  - constants HORA_MAX_MSD=2, HORA_MAX_LSD=3, BCD_MAX=9;
  - function bcd_inc_hora (BCD step with wrap and illegal recovery);
  - function bcd24_para_12 (returns digits and pm).
- Natural sub-module: maq_h_ajuste, the auto-repeat FSM plus timer. It outputs adj_step and is reusable by the minutes adjust.

Test Plan:
- RST_HORA=23. Assert reset, then one carry pulse with enable=1 → count 00, maqh_incrementadia high for exactly one cycle on that edge, 24h display shows 0/0.
- Count 09, carry pulse → 10. Count 19, carry pulse → 20. Pulse with enable=0 → no change, no day pulse.
- HOLD_CYCLES=4, REPEAT_CYCLES=3, count 05. Hold maqh_ajuste high for 12 cycles → steps at cycles 0, 4, 7, 10, count 09. Release → FSM IDLE and no further steps. A 1-cycle press gives exactly +1.
- Count 23, adjust press with enable=0 → 00 with maqh_incrementadia kept 0. Carry and adjust in the same cycle from 07 → 08, not 09.
- modo12=1, step through the day → 00 gives 12/pm0, 11 gives 11/pm0, 12 gives 12/pm1, 13 gives 01/pm1, 23 gives 11/pm1. Toggle to 24h at 13 → next edge shows 13/pm0.
- Assert reset while in REPETE at count 14 → next edge count = RST_HORA and FSM IDLE. Button still held after reset → one immediate step, then the HOLD wait restarts.
